// File: rtl/tdt_dm_cdc_pkg.sv
// Shared definitions for the debug-module req/ack clock-domain crossing.
package tdt_dm_cdc_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RLS  = 2'd2;

  // Width needed to hold a timeout count that saturates at to_cyc.
  function automatic int unsigned to_cnt_w(input int unsigned to_cyc);
    return unsigned'($clog2(to_cyc + 1));
  endfunction

endpackage

// File: rtl/tdt_dm_cdc_ack_sync.sv
// Multi-stage synchronizer bringing the destination-domain ack into src_clk.
module tdt_dm_cdc_ack_sync #(
  parameter int unsigned SYNC_NUM = 2
) (
  input  logic src_clk,
  input  logic src_rst,
  input  logic ack_async_i,
  output logic ack_s_o
);

  logic [SYNC_NUM-1:0] sync_q;

  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_NUM-2:0], ack_async_i};
    end
  end

  assign ack_s_o = sync_q[SYNC_NUM-1];

endmodule

// File: rtl/tdt_dm_cdc_req_ctrl.sv
// Source-side sequencer for a 4-phase req/ack crossing carrying one DW-bit word,
// with completion pulse, busy indication and a sticky ack-timeout error.
module tdt_dm_cdc_req_ctrl
  import tdt_dm_cdc_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned SYNC_NUM = 2,
  parameter int unsigned TO_CYC   = 256
) (
  input  logic          src_clk,
  input  logic          src_rst,
  input  logic          cmd_vld,
  input  logic [DW-1:0] cmd_data,
  output logic          cmd_rdy,
  output logic          cdc_req,
  output logic [DW-1:0] cdc_data,
  input  logic          cdc_ack_async,
  output logic          done,
  output logic          busy,
  output logic          err,
  input  logic          err_clr
);

  localparam int unsigned   CW     = to_cnt_w(TO_CYC);
  localparam logic [CW-1:0] TO_MAX = CW'(TO_CYC);

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          ack_s;
  logic          accept;
  logic          err_set;

  tdt_dm_cdc_ack_sync #(
    .SYNC_NUM(SYNC_NUM)
  ) u_ack_sync (
    .src_clk    (src_clk),
    .src_rst    (src_rst),
    .ack_async_i(cdc_ack_async),
    .ack_s_o    (ack_s)
  );

  // A stale ack (e.g. after a mid-transfer reset) must fall before a new request.
  assign cmd_rdy = (state_q == IDLE) & ~ack_s;
  assign accept  = cmd_vld & cmd_rdy;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = cmd_data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = RLS;
        end
      end
      RLS: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Error fires once when the count first reaches TO_MAX; saturation keeps it
  // from re-asserting, so err_clr is effective while the FSM keeps waiting.
  always_comb begin
    cnt_d   = cnt_q;
    err_set = 1'b0;
    if ((state_d != state_q) || (state_q == IDLE)) begin
      cnt_d = '0;
    end else if (cnt_q != TO_MAX) begin
      cnt_d   = cnt_q + 1'b1;
      err_set = (cnt_d == TO_MAX);
    end
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign cdc_req  = req_q;
  assign cdc_data = data_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule
